// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate block: FSM state encoding and
// default operand/accumulator widths.
package mac_pkg;

    localparam int DATA_W = 4;
    localparam int ACC_W  = 2 * DATA_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/mac_mult.sv
// Combinational unsigned multiplier producing the full-width product.
module mac_mult #(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [2*DATA_W-1:0] prod
);

    assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

endmodule

// File: rtl/mac_accumulator.sv
// Sums N_TERMS unsigned products per result with a valid/ready handshake on both
// sides; overflow flags any carry out of the accumulator during the sum.
module mac_accumulator #(
    parameter int DATA_W  = mac_pkg::DATA_W,
    parameter int ACC_W   = mac_pkg::ACC_W,
    parameter int N_TERMS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  result,
    output logic              overflow
);

    import mac_pkg::state_t;
    import mac_pkg::IDLE;
    import mac_pkg::ACCUM;
    import mac_pkg::DONE;

    localparam int PW    = 2 * DATA_W;
    localparam int SW    = ((ACC_W > PW) ? ACC_W : PW) + 1;
    localparam int CNT_W = $clog2(N_TERMS + 1);

    // Wrapping add; the MSB of the return value is the carry out of bit ACC_W-1.
    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] acc_v,
                                               input logic [PW-1:0]    prod_v);
        logic [SW-1:0] s;
        s = SW'(acc_v) + SW'(prod_v);
        return {|s[SW-1:ACC_W], s[ACC_W-1:0]};
    endfunction

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   count;
    logic               ovf;
    logic [PW-1:0]      prod;
    logic [ACC_W:0]     sum_c;
    logic               accept;
    logic               last;

    mac_mult #(.DATA_W(DATA_W)) u_mult (
        .a    (a),
        .b    (b),
        .prod (prod)
    );

    assign sum_c  = acc_add(acc, prod);
    assign accept = in_valid && in_ready && !clr;
    assign last   = (count == CNT_W'(N_TERMS - 1));

    assign in_ready  = !rst && (state != DONE);
    assign out_valid = !rst && (state == DONE);
    assign result    = acc;
    assign overflow  = ovf;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc   <= sum_c[ACC_W-1:0];
                        ovf   <= ovf | sum_c[ACC_W];
                        count <= count + 1'b1;
                        state <= last ? DONE : ACCUM;
                    end
                end
                DONE: begin
                    // Handshake edge empties the block; no operand is taken on it.
                    if (out_ready) begin
                        state <= IDLE;
                        acc   <= '0;
                        count <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    acc   <= '0;
                    count <= '0;
                    ovf   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator with DATA_W=4, ACC_W=9, N_TERMS=4.
module tb_mac_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] result;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    mac_accumulator #(.DATA_W(4), .ACC_W(9), .N_TERMS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Presents one pair and holds it until the edge that accepts it.
    task automatic push(input logic [3:0] av, input logic [3:0] bv);
        int n;
        n = 0;
        in_valid = 1'b1;
        a = av;
        b = bv;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("push_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_result", 32'(result), 32'd0);

        // Back-to-back pairs: 15+14+225+1 = 255
        push(4'd3, 4'd5);
        push(4'd2, 4'd7);
        push(4'd15, 4'd15);
        check("b2b_not_done", 32'(out_valid), 32'd0);
        push(4'd1, 4'd1);
        check("b2b_out_valid", 32'(out_valid), 32'd1);
        check("b2b_result", 32'(result), 32'd255);
        check("b2b_overflow", 32'(overflow), 32'd0);
        check("b2b_in_ready", 32'(in_ready), 32'd0);
        consume();
        check("b2b_idle_valid", 32'(out_valid), 32'd0);
        check("b2b_idle_result", 32'(result), 32'd0);

        // 4 x 225 = 900 -> 388 with sticky overflow (last add does not carry)
        for (int i = 0; i < 4; i++) push(4'd15, 4'd15);
        check("ovf_result", 32'(result), 32'd388);
        check("ovf_flag", 32'(overflow), 32'd1);
        consume();
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Gapped input, result held while consumer stalls, offered pair ignored
        push(4'd3, 4'd5);  tick(); tick();
        push(4'd2, 4'd7);  tick(); tick();
        push(4'd15, 4'd15); tick(); tick();
        check("gap_not_done", 32'(out_valid), 32'd0);
        check("gap_partial", 32'(result), 32'd254);
        push(4'd1, 4'd1);
        in_valid = 1'b1; a = 4'd9; b = 4'd9;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", 32'(result), 32'd255);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        consume();
        check("gap_idle_valid", 32'(out_valid), 32'd0);
        check("gap_idle_in_ready", 32'(in_ready), 32'd1);
        check("gap_idle_result", 32'(result), 32'd0);

        // clr mid-sum with a pair offered on the same edge
        push(4'd15, 4'd15);
        push(4'd15, 4'd15);
        check("pre_clr_acc", 32'(result), 32'd450);
        clr = 1'b1; in_valid = 1'b1; a = 4'd1; b = 4'd1;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        check("clr_acc", 32'(result), 32'd0);
        check("clr_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 3; i++) push(4'd1, 4'd1);
        check("clr_count_reset", 32'(out_valid), 32'd0);
        push(4'd1, 4'd1);
        check("clr_result", 32'(result), 32'd4);
        check("clr_result_ovf", 32'(overflow), 32'd0);
        check("clr_valid", 32'(out_valid), 32'd1);
        consume();

        // rst while holding a result
        for (int i = 0; i < 4; i++) push(4'd1, 4'd2);
        check("pre_rst_result", 32'(result), 32'd8);
        rst = 1'b1;
        tick();
        check("rst_done_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_done_acc", 32'(result), 32'd0);
        check("rst_done_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) push(4'd2, 4'd3);
        check("after_rst_result", 32'(result), 32'd24);
        consume();

        // in_valid held across the handshake edge
        for (int i = 0; i < 4; i++) push(4'd1, 4'd1);
        check("hs_pre_result", 32'(result), 32'd4);
        in_valid = 1'b1; a = 4'd2; b = 4'd2; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hs_no_accept", 32'(result), 32'd0);
        check("hs_valid_low", 32'(out_valid), 32'd0);
        check("hs_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("hs_first_accept", 32'(result), 32'd4);
        a = 4'd3; b = 4'd3;
        tick();
        check("hs_second_accept", 32'(result), 32'd13);
        in_valid = 1'b0;
        push(4'd1, 4'd1);
        check("hs_three_terms", 32'(out_valid), 32'd0);
        push(4'd1, 4'd1);
        check("hs_result", 32'(result), 32'd15);
        check("hs_done", 32'(out_valid), 32'd1);

        // clr discards an unconsumed result
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_done_valid", 32'(out_valid), 32'd0);
        check("clr_done_result", 32'(result), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
